// File: rtl/watch_pkg.sv
// Shared constants and types for the watch top level.
// Mode indices of the function-mode ring, key bit positions within the
// {up,down,left,right,enter,esc} key vector, default widths and the
// sequencer state type.
package watch_pkg;

  localparam int unsigned N_MODES = 7;
  localparam int unsigned OUT_W   = 48;
  localparam int unsigned N_KEYS  = 6;

  localparam int unsigned MODE_DATE      = 0;
  localparam int unsigned MODE_CLOCK     = 1;
  localparam int unsigned MODE_ALARM     = 2;
  localparam int unsigned MODE_STOPWATCH = 3;
  localparam int unsigned MODE_TIMER     = 4;
  localparam int unsigned MODE_DDAY      = 5;
  localparam int unsigned MODE_LADDER    = 6;

  localparam int unsigned KEY_ESC   = 0;
  localparam int unsigned KEY_ENTER = 1;
  localparam int unsigned KEY_RIGHT = 2;
  localparam int unsigned KEY_LEFT  = 3;
  localparam int unsigned KEY_DOWN  = 4;
  localparam int unsigned KEY_UP    = 5;

  typedef enum logic {
    StRun,
    StAlert
  } seq_state_e;

endpackage

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   d_i     level inputs
//   rise_o  one-cycle high where d_i goes 0->1
// The previous-value register resets to all ones so that a level already held
// through reset is not reported as an edge.
module rise_detect #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '1;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/mode_sequencer.sv
// Central controller of the watch: owns the one-hot function-mode ring, shares the
// single display word between function modules and arbitrates their alarm requests.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   keys_i       {up,down,left,right,enter,esc} debounced levels
//   norm_i       module i idle (mode switch allowed while it is active)
//   out_bus_i    module i display word at [i*OutW +: OutW]
//   alarm_req_i  module i alert request (rising edge is the event)
//   mode_o       one-hot active module
//   out_o        registered display word of the active module
//   o_m_o        {alarm, pad, mode}
//   alarm_o      alert indicator
//   alarm_ack_o  one-cycle pulse to the requester whose alert was acknowledged
//   key_block_o  key edges of this cycle are consumed by the controller
module mode_sequencer
  import watch_pkg::*;
#(
  parameter int unsigned NModes      = N_MODES,
  parameter int unsigned OutW        = OUT_W,
  parameter int unsigned InitMode    = MODE_STOPWATCH,
  parameter int unsigned AlarmCycles = 60000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_KEYS-1:0]      keys_i,
  input  logic [NModes-1:0]      norm_i,
  input  logic [NModes*OutW-1:0] out_bus_i,
  input  logic [NModes-1:0]      alarm_req_i,
  output logic [NModes-1:0]      mode_o,
  output logic [OutW-1:0]        out_o,
  output logic [7:0]             o_m_o,
  output logic                   alarm_o,
  output logic [NModes-1:0]      alarm_ack_o,
  output logic                   key_block_o
);

  localparam int unsigned     CntW     = (AlarmCycles > 2) ? $clog2(AlarmCycles) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(AlarmCycles - 1);
  localparam logic [NModes-1:0] ModeInit = NModes'(1) << InitMode;

  logic [N_KEYS-1:0] key_rise;
  logic [NModes-1:0] req_rise;

  rise_detect #(
    .W (N_KEYS)
  ) u_key_rise (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (keys_i),
    .rise_o (key_rise)
  );

  rise_detect #(
    .W (NModes)
  ) u_req_rise (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (alarm_req_i),
    .rise_o (req_rise)
  );

  seq_state_e        state_q, state_d;
  logic [NModes-1:0] mode_q, mode_d;
  logic [NModes-1:0] saved_q, saved_d;
  logic [NModes-1:0] pending_q, pending_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              alarm_q, alarm_d;
  logic [NModes-1:0] ack_q, ack_d;
  logic [OutW-1:0]   out_q, out_d;

  logic [NModes-1:0] cand, pick, mode_up, mode_dn;
  logic              key_up, key_dn, mode_norm, switch_req;

  assign cand = req_rise | pending_q;
  // Isolate the lowest set bit: lowest index wins arbitration.
  assign pick = cand & (~cand + NModes'(1));

  assign mode_up = {mode_q[NModes-2:0], mode_q[NModes-1]};
  assign mode_dn = {mode_q[0], mode_q[NModes-1:1]};

  assign key_up     = key_rise[KEY_UP];
  assign key_dn     = key_rise[KEY_DOWN];
  assign mode_norm  = |(norm_i & mode_q);
  // Simultaneous up and down edges cancel.
  assign switch_req = mode_norm & (key_up ^ key_dn);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    saved_d     = saved_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    alarm_d     = alarm_q;
    ack_d       = '0;
    key_block_o = 1'b0;
    case (state_q)
      StRun: begin
        // Requests take priority over a key-driven mode switch in the same cycle.
        if (|cand) begin
          saved_d   = mode_q;
          mode_d    = pick;
          pending_d = cand & ~pick;
          alarm_d   = 1'b1;
          cnt_d     = '0;
          state_d   = StAlert;
        end else if (switch_req) begin
          key_block_o = 1'b1;
          mode_d      = key_up ? mode_up : mode_dn;
        end
      end
      StAlert: begin
        key_block_o = 1'b1;
        // mode_q is the module under service; its own re-request is dropped.
        pending_d   = pending_q | (req_rise & ~mode_q);
        if (|key_rise) begin
          ack_d   = mode_q;
          mode_d  = saved_q;
          alarm_d = 1'b0;
          state_d = StRun;
        end else if (cnt_q == CntLast) begin
          mode_d  = saved_q;
          alarm_d = 1'b0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    out_d = '0;
    for (int unsigned i = 0; i < NModes; i++) begin
      if (mode_q[i]) begin
        out_d = out_d | out_bus_i[i*OutW +: OutW];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      mode_q    <= ModeInit;
      saved_q   <= ModeInit;
      pending_q <= '0;
      cnt_q     <= '0;
      alarm_q   <= 1'b0;
      ack_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      saved_q   <= saved_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      alarm_q   <= alarm_d;
      ack_q     <= ack_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    o_m_o             = '0;
    o_m_o[NModes-1:0] = mode_q;
    o_m_o[7]          = alarm_q;
  end

  assign mode_o      = mode_q;
  assign out_o       = out_q;
  assign alarm_o     = alarm_q;
  assign alarm_ack_o = ack_q;

endmodule
